// File: rtl/mspe_stream_pkg.sv
// rtl/mspe_stream_pkg.sv - shared stream beat type and emitter state encoding
package mspe_stream_pkg;

   localparam int STREAM_W = 512;

   typedef struct packed {
      logic                sop;
      logic                eop;
      logic [STREAM_W-1:0] data;
   } stream_beat_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOP,
      STREAM
   } emitter_state_t;

endpackage

// File: rtl/stream_beat_fifo.sv
// rtl/stream_beat_fifo.sv - first-word-fall-through beat FIFO with occupancy count
module stream_beat_fifo
   import mspe_stream_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_valid,
   input  stream_beat_t     push_beat,
   input  logic             pop,
   output logic             head_valid,
   output stream_beat_t     head_beat,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   stream_beat_t     mem_q [DEPTH];
   stream_beat_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_pop   = pop && (count_q != '0);
      if (push_valid) begin
         mem_d[wr_ptr_q] = push_beat;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_valid) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_valid = (count_q != '0);
   assign head_beat  = mem_q[rd_ptr_q];
   assign count      = count_q;

   no_push_when_full: assert property (@(posedge clk) disable iff (reset)
      !(push_valid && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/stream_data_emitter.sv
// rtl/stream_data_emitter.sv - round-robin packet collector from cores onto the src_* stream
module stream_data_emitter
   import mspe_stream_pkg::*;
#(
   parameter int CORES         = 4,
   parameter int DATA_W        = 512,
   parameter int FIFO_DEPTH    = 16,
   parameter int MAX_PKT_BEATS = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CORES-1:0]          core_src_req,
   output logic [CORES-1:0]          core_src_grant,
   input  logic [CORES-1:0]          core_src_valid,
   input  logic [CORES-1:0]          core_src_sop,
   input  logic [CORES-1:0]          core_src_eop,
   input  logic [CORES*DATA_W-1:0]   core_src_q,
   output logic [DATA_W-1:0]         src_data,
   output logic                      src_valid,
   output logic                      src_sop,
   output logic                      src_eop,
   input  logic                      src_ready,
   output logic                      done_valid,
   output logic [$clog2(CORES)-1:0]  done_id,
   output logic                      busy,
   output logic                      overflow,
   output logic                      protocol_error
);

   localparam int ID_W  = $clog2(CORES);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BC_W  = $clog2(MAX_PKT_BEATS + 2);

   emitter_state_t   state_q, state_d;
   logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]  last_id_q, last_id_d;
   logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic             overflow_q, overflow_d;
   logic             perr_q, perr_d;

   logic             push_valid;
   stream_beat_t     push_beat;
   logic             head_valid;
   stream_beat_t     head_beat;
   logic [CNT_W-1:0] fifo_count;

   logic             pick_found;
   logic [ID_W-1:0]  pick_id;
   logic             room_for_pkt;
   logic             done_pulse;
   logic             beat_valid, beat_sop, beat_eop;
   logic [DATA_W-1:0] beat_data;

   stream_beat_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (push_valid),
      .push_beat  (push_beat),
      .pop        (src_ready),
      .head_valid (head_valid),
      .head_beat  (head_beat),
      .count      (fifo_count)
   );

   // Round-robin search starting just after the last granted core.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      for (int k = 1; k <= CORES; k++) begin
         if (!pick_found && core_src_req[(int'(last_id_q) + k) % CORES]) begin
            pick_found = 1'b1;
            pick_id    = ID_W'((int'(last_id_q) + k) % CORES);
         end
      end
   end

   // Cores cannot be stalled mid-packet, so only grant when a whole packet fits.
   assign room_for_pkt = (FIFO_DEPTH - int'(fifo_count)) >= MAX_PKT_BEATS;

   assign beat_valid = core_src_valid[gnt_id_q];
   assign beat_sop   = core_src_sop[gnt_id_q];
   assign beat_eop   = core_src_eop[gnt_id_q];
   assign beat_data  = core_src_q[int'(gnt_id_q)*DATA_W +: DATA_W];

   always_comb begin
      state_d        = state_q;
      gnt_id_d       = gnt_id_q;
      last_id_d      = last_id_q;
      beat_cnt_d     = beat_cnt_q;
      overflow_d     = overflow_q;
      perr_d         = perr_q;
      push_valid     = 1'b0;
      push_beat.sop  = 1'b0;
      push_beat.eop  = 1'b0;
      push_beat.data = beat_data;
      done_pulse     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_found && room_for_pkt) begin
               gnt_id_d  = pick_id;
               last_id_d = pick_id;
               state_d   = WAIT_SOP;
            end
         end
         WAIT_SOP: begin
            if (beat_valid) begin
               if (beat_sop) begin
                  push_valid    = 1'b1;
                  push_beat.sop = 1'b1;
                  push_beat.eop = beat_eop;
                  beat_cnt_d    = BC_W'(1);
                  state_d       = STREAM;
               end else begin
                  perr_d = 1'b1;
               end
               if (beat_eop) begin
                  done_pulse = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         STREAM: begin
            if (beat_valid) begin
               if (beat_cnt_q <= BC_W'(MAX_PKT_BEATS)) begin
                  beat_cnt_d = beat_cnt_q + BC_W'(1);
               end
               if (beat_cnt_q < BC_W'(MAX_PKT_BEATS)) begin
                  push_valid    = 1'b1;
                  push_beat.eop = beat_eop || (beat_cnt_q == BC_W'(MAX_PKT_BEATS - 1));
                  if ((beat_cnt_q == BC_W'(MAX_PKT_BEATS - 1)) && !beat_eop) begin
                     overflow_d = 1'b1;
                  end
               end
               if (beat_eop) begin
                  done_pulse = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_id_q   <= '0;
         last_id_q  <= ID_W'(CORES - 1);
         beat_cnt_q <= '0;
         overflow_q <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_id_q   <= gnt_id_d;
         last_id_q  <= last_id_d;
         beat_cnt_q <= beat_cnt_d;
         overflow_q <= overflow_d;
         perr_q     <= perr_d;
      end
   end

   assign core_src_grant = (state_q != IDLE) ? (CORES'(1) << gnt_id_q) : '0;
   assign done_valid     = done_pulse && !reset;
   assign done_id        = (done_pulse && !reset) ? gnt_id_q : '0;
   assign src_valid      = head_valid;
   assign src_data       = head_valid ? head_beat.data : '0;
   assign src_sop        = head_valid && head_beat.sop;
   assign src_eop        = head_valid && head_beat.eop;
   assign busy           = (state_q != IDLE) || head_valid;
   assign overflow       = overflow_q;
   assign protocol_error = perr_q;

endmodule

// File: tb/tb_stream_data_emitter.sv
// tb/tb_stream_data_emitter.sv - scoreboard bench for stream_data_emitter
module tb_stream_data_emitter;

   localparam int CORES  = 4;
   localparam int DATA_W = 512;
   localparam int DEPTH  = 16;
   localparam int MAXB   = 8;

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] data;
   } exp_beat_t;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [CORES-1:0]         core_src_req;
   logic [CORES-1:0]         core_src_grant;
   logic [CORES-1:0]         core_src_valid;
   logic [CORES-1:0]         core_src_sop;
   logic [CORES-1:0]         core_src_eop;
   logic [CORES*DATA_W-1:0]  core_src_q;
   logic [DATA_W-1:0]        src_data;
   logic                     src_valid, src_sop, src_eop, src_ready;
   logic                     done_valid;
   logic [1:0]               done_id;
   logic                     busy, overflow, protocol_error;

   exp_beat_t exp_q[$];
   int        exp_done_q[$];
   int        grant_log[$];
   int        vectors = 0;
   int        errors  = 0;
   int        pop_cnt = 0;
   int        last_grant_pop = 0;
   bit        rand_done = 0;

   always #5 clk = ~clk;

   stream_data_emitter #(
      .CORES(CORES), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .MAX_PKT_BEATS(MAXB)
   ) dut (
      .clk(clk), .reset(reset),
      .core_src_req(core_src_req), .core_src_grant(core_src_grant),
      .core_src_valid(core_src_valid), .core_src_sop(core_src_sop),
      .core_src_eop(core_src_eop), .core_src_q(core_src_q),
      .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop),
      .src_eop(src_eop), .src_ready(src_ready),
      .done_valid(done_valid), .done_id(done_id), .busy(busy),
      .overflow(overflow), .protocol_error(protocol_error)
   );

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [CORES-1:0] req, input int last);
      for (int k = 1; k <= CORES; k++) begin
         if (req[(last + k) % CORES]) return (last + k) % CORES;
      end
      return -1;
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Monitor: compares every accepted output beat, done pulse and new grant.
   logic [CORES-1:0] prev_req, prev_gnt;
   int               last_g = CORES - 1;
   always @(negedge clk) begin
      exp_beat_t e;
      int        p;
      if (reset) begin
         last_g   = CORES - 1;
         prev_gnt = '0;
         prev_req = core_src_req;
      end else begin
         if (core_src_grant != '0) check("grant_onehot", DATA_W'($onehot(core_src_grant)), 1);
         if (core_src_grant != '0 && prev_gnt == '0) begin
            p = rr_pick(prev_req, last_g);
            check("grant_rr", DATA_W'(core_src_grant), (p >= 0) ? DATA_W'(1) << p : '0);
            if (p >= 0) last_g = p;
         end
         if (src_valid && src_ready) begin
            if (exp_q.size() == 0) begin
               vectors++; errors++;
               $display("FAIL unexpected_beat: got data %0h expected no beat", src_data);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", src_data, e.data);
               check("beat_sop", DATA_W'(src_sop), DATA_W'(e.sop));
               check("beat_eop", DATA_W'(src_eop), DATA_W'(e.eop));
               pop_cnt++;
            end
         end
         if (done_valid) begin
            if (exp_done_q.size() == 0) begin
               vectors++; errors++;
               $display("FAIL unexpected_done: got id %0d expected no done", done_id);
            end else begin
               check("done_id", DATA_W'(done_id), DATA_W'(exp_done_q.pop_front()));
               check("done_sync", DATA_W'(core_src_valid[done_id] && core_src_eop[done_id]), 1);
            end
         end
         prev_gnt = core_src_grant;
         prev_req = core_src_req;
      end
   end

   // Reference: dropped non-sop lead beat, packet truncated to MAXB with eop forced.
   task automatic send_packet(input int c, input int n, input bit bad, input bit fixed);
      logic [DATA_W-1:0] dat[16];
      int t = 0;
      for (int i = 0; i < n; i++) dat[i] = fixed ? DATA_W'(8'h11 * (i + 1)) : rand_data();
      @(posedge clk); #1;
      core_src_req[c] = 1'b1;
      do begin @(negedge clk); t++; end while (!core_src_grant[c] && t < 3000);
      if (!core_src_grant[c]) begin
         vectors++; errors++;
         $display("FAIL grant_timeout: core %0d got no grant, expected one", c);
         core_src_req[c] = 1'b0;
         return;
      end
      grant_log.push_back(c);
      last_grant_pop = pop_cnt;
      for (int i = 0; i < n && i < MAXB; i++)
         exp_q.push_back({(i == 0), (i == n - 1) || (i == MAXB - 1), dat[i]});
      exp_done_q.push_back(c);
      @(posedge clk); #1;
      for (int i = (bad ? -1 : 0); i < n; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            core_src_valid[c] = 1'b0;
            @(posedge clk); #1;
         end
         core_src_valid[c] = 1'b1;
         core_src_sop[c]   = (i == 0);
         core_src_eop[c]   = (i == n - 1);
         core_src_q[c*DATA_W +: DATA_W] = (i < 0) ? rand_data() : dat[i];
         if (i == n - 1) core_src_req[c] = 1'b0;
         @(posedge clk); #1;
      end
      core_src_valid[c] = 1'b0;
      core_src_sop[c]   = 1'b0;
      core_src_eop[c]   = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
      check("drain_beats_left", DATA_W'(exp_q.size()), 0);
      check("drain_dones_left", DATA_W'(exp_done_q.size()), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      core_src_req = '0; core_src_valid = '0; core_src_sop = '0; core_src_eop = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      exp_done_q.delete();
   endtask

   task automatic core_loop(input int c);
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         send_packet(c, $urandom_range(1, 10), ($urandom_range(0, 7) == 0), 1'b0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      errors++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int rel_pop;
      logic [CORES-1:0] seen;
      reset = 1'b1; src_ready = 1'b1;
      core_src_req = '0; core_src_valid = '0; core_src_sop = '0; core_src_eop = '0;
      core_src_q = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_src_valid", DATA_W'(src_valid), 0);
      check("rst_src_data", src_data, 0);
      check("rst_grant", DATA_W'(core_src_grant), 0);
      check("rst_done", DATA_W'(done_valid), 0);
      check("rst_busy", DATA_W'(busy), 0);
      check("rst_flags", DATA_W'({overflow, protocol_error}), 0);

      // Single 3-beat packet from core 1 with known data.
      send_packet(1, 3, 1'b0, 1'b1);
      wait_drain();

      // Arbitration order after reset: 0, 2, then 3 ahead of 2.
      do_reset();
      grant_log.delete();
      fork
         send_packet(0, 2, 1'b0, 1'b0);
         send_packet(2, 3, 1'b0, 1'b0);
      join
      fork
         send_packet(2, 2, 1'b0, 1'b0);
         send_packet(3, 2, 1'b0, 1'b0);
      join
      wait_drain();
      check("arb_count", DATA_W'(grant_log.size()), 4);
      if (grant_log.size() == 4) begin
         check("arb_0", DATA_W'(grant_log[0]), 0);
         check("arb_1", DATA_W'(grant_log[1]), 2);
         check("arb_2", DATA_W'(grant_log[2]), 3);
         check("arb_3", DATA_W'(grant_log[3]), 2);
      end

      // FIFO fills to 16 under backpressure; core 2 waits for room.
      src_ready = 1'b0;
      send_packet(0, 8, 1'b0, 1'b0);
      send_packet(1, 8, 1'b0, 1'b0);
      rel_pop = pop_cnt;
      fork
         send_packet(2, 3, 1'b0, 1'b0);
         begin
            seen = '0;
            repeat (20) begin @(negedge clk); seen |= core_src_grant; end
            check("full_no_grant", DATA_W'(seen), 0);
            @(posedge clk); #1 src_ready = 1'b1;
         end
      join
      check("grant_after_8_pops", DATA_W'((last_grant_pop - rel_pop) >= MAXB), 1);
      wait_drain();

      // Oversize packet truncated to MAXB beats.
      check("ovf_before", DATA_W'(overflow), 0);
      send_packet(3, 10, 1'b0, 1'b0);
      wait_drain();
      check("ovf_after", DATA_W'(overflow), 1);

      // Beat before sop is dropped and flagged.
      check("perr_before", DATA_W'(protocol_error), 0);
      send_packet(0, 2, 1'b1, 1'b0);
      wait_drain();
      check("perr_after", DATA_W'(protocol_error), 1);
      check("ovf_sticky", DATA_W'(overflow), 1);

      // Reset in the middle of a 5-beat packet.
      src_ready = 1'b0;
      @(posedge clk); #1 core_src_req[0] = 1'b1;
      begin
         int t = 0;
         do begin @(negedge clk); t++; end while (!core_src_grant[0] && t < 100);
         check("midrst_grant", DATA_W'(core_src_grant[0]), 1);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         core_src_valid[0] = 1'b1; core_src_sop[0] = (i == 0); core_src_eop[0] = 1'b0;
         core_src_q[0 +: DATA_W] = rand_data();
      end
      @(posedge clk); #1;
      reset = 1'b1; core_src_req = '0; core_src_valid = '0; core_src_sop = '0;
      @(posedge clk); #1 reset = 1'b0;
      src_ready = 1'b1;
      @(negedge clk);
      check("midrst_src_valid", DATA_W'(src_valid), 0);
      check("midrst_grant0", DATA_W'(core_src_grant), 0);
      check("midrst_busy", DATA_W'(busy), 0);
      check("midrst_flags", DATA_W'({overflow, protocol_error}), 0);
      send_packet(0, 4, 1'b0, 1'b0);
      wait_drain();

      // Randomised traffic from all cores with random backpressure.
      fork
         begin
            fork
               core_loop(0);
               core_loop(1);
               core_loop(2);
               core_loop(3);
            join
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1 src_ready = ($urandom_range(0, 3) != 0);
            end
            src_ready = 1'b1;
         end
      join
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
